// File: rtl/operand_loader_if.sv
// ============================================================================
// operand_loader_if : byte-stream input and 8-operand frame output bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface operand_loader_if #(
    parameter int W = 8
);
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] in3;
    logic [W-1:0] in4;
    logic [W-1:0] in5;
    logic [W-1:0] in6;
    logic [W-1:0] in7;
    logic [7:0]   frame_cnt;

    // master: the loader itself; slave: the upstream source plus adder tree side
    modport master (
        input  s_valid, s_data, flush, out_ready,
        output s_ready, out_valid, in0, in1, in2, in3, in4, in5, in6, in7, frame_cnt
    );

    modport slave (
        output s_valid, s_data, flush, out_ready,
        input  s_ready, out_valid, in0, in1, in2, in3, in4, in5, in6, in7, frame_cnt
    );
endinterface

`default_nettype wire

// File: rtl/operand_loader.sv
// ============================================================================
// operand_loader : groups 8 serial bytes into one parallel frame, double buffered
// Revision 1.0
// ============================================================================
`default_nettype none

module operand_loader #(
    parameter int W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    operand_loader_if.master bus
);

    // Encoding is {cap_full, out_valid}; 2'b10 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PRESENT = 2'b01,
        ST_PARKED  = 2'b11
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [W-1:0] cap_q [8];
    logic [W-1:0] cap_d [8];
    logic [W-1:0] out_q [8];
    logic [W-1:0] out_d [8];
    logic [7:0]   frame_cnt_q, frame_cnt_d;

    logic w_out_valid;
    logic w_cap_full;
    logic w_slot_free;
    logic w_accept;
    logic w_fire;
    logic w_last;

    assign w_out_valid = state_q[0];
    assign w_cap_full  = state_q[1];
    assign w_slot_free = !w_out_valid || bus.out_ready;
    assign w_accept    = bus.s_valid && !w_cap_full && !bus.flush;
    assign w_fire      = w_out_valid && bus.out_ready;
    assign w_last      = w_accept && (idx_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cap_d       = cap_q;
        out_d       = out_q;
        frame_cnt_d = frame_cnt_q + {7'd0, w_fire};

        if (w_accept) begin
            cap_d[idx_q] = bus.s_data;
            idx_d        = idx_q + 3'd1;
        end

        if (bus.flush) begin
            // Output side keeps handshaking normally; only capture state is dropped.
            idx_d   = 3'd0;
            state_d = (w_fire || state_q == ST_EMPTY) ? ST_EMPTY : ST_PRESENT;
        end else begin
            case (state_q)
                ST_EMPTY, ST_PRESENT: begin
                    if (w_last && w_slot_free) begin
                        for (int i = 0; i < 7; i++) begin
                            out_d[i] = cap_q[i];
                        end
                        out_d[7] = bus.s_data;
                        state_d  = ST_PRESENT;
                    end else if (w_last) begin
                        state_d = ST_PARKED;
                    end else if (w_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_PARKED: begin
                    if (w_slot_free) begin
                        out_d   = cap_q;
                        state_d = ST_PRESENT;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            idx_q       <= 3'd0;
            cap_q       <= '{default: '0};
            out_q       <= '{default: '0};
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cap_q       <= cap_d;
            out_q       <= out_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.s_ready   = !w_cap_full;
    assign bus.out_valid = w_out_valid;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.in0       = out_q[0];
    assign bus.in1       = out_q[1];
    assign bus.in2       = out_q[2];
    assign bus.in3       = out_q[3];
    assign bus.in4       = out_q[4];
    assign bus.in5       = out_q[5];
    assign bus.in6       = out_q[6];
    assign bus.in7       = out_q[7];

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ============================================================================
// tb_operand_loader : directed self-checking bench for operand_loader
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_operand_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    operand_loader_if #(.W(8)) bus ();

    operand_loader #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] got [8];
    always_comb begin
        got[0] = bus.in0; got[1] = bus.in1; got[2] = bus.in2; got[3] = bus.in3;
        got[4] = bus.in4; got[5] = bus.in5; got[6] = bus.in6; got[7] = bus.in7;
    end

    // Presents one byte starting at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] d);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: s_ready=%0b required 1", bus.s_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        bus.s_valid = 0; bus.s_data = 0; bus.flush = 0; bus.out_ready = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.frame_cnt !== 8'd0 || got[0] !== 8'd0 || got[7] !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%0b s_ready=%0b frame_cnt=%0d in0=%h in7=%h required 0 1 0 00 00",
                     bus.out_valid, bus.s_ready, bus.frame_cnt, got[0], got[7]);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i));
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid: out_valid=%0b required 1", bus.out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL single_in%0d: got %h required %h", i, got[i], 8'(i + 1));
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_after: out_valid=%0b frame_cnt=%0d required 0 1", bus.out_valid, bus.frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) send(8'(i));
        checks++;
        if (bus.out_valid !== 1'b1 || bus.s_ready !== 1'b0 || got[0] !== 8'h01 || got[7] !== 8'h08) begin
            errors++;
            $display("FAIL bp_parked: out_valid=%0b s_ready=%0b in0=%h in7=%h required 1 0 01 08",
                     bus.out_valid, bus.s_ready, got[0], got[7]);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.s_ready !== 1'b1 || got[0] !== 8'h09 || got[7] !== 8'h10 || bus.frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bp_transfer: out_valid=%0b s_ready=%0b in0=%h in7=%h frame_cnt=%0d required 1 1 09 10 2",
                     bus.out_valid, bus.s_ready, got[0], got[7], bus.frame_cnt);
        end
        @(negedge clk);
        checks++;
        if (got[3] !== 8'h0c || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: in3=%h out_valid=%0b required 0c 1", got[3], bus.out_valid);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.frame_cnt !== 8'd3) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%0b frame_cnt=%0d required 0 3", bus.out_valid, bus.frame_cnt);
        end
    endtask

    task automatic test_flush_partial();
        bus.out_ready = 1'b1;
        send(8'hAA); send(8'hBB); send(8'hCC);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i));
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL flushp_valid: out_valid=%0b required 1", bus.out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL flushp_in%0d: got %h required %h", i, got[i], 8'(i + 1));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_flush_parked();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) send(8'(i));
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++; $display("FAIL flushk_pre: s_ready=%0b required 0", bus.s_ready);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.s_ready !== 1'b1 || bus.out_valid !== 1'b1 || got[0] !== 8'h01 || got[7] !== 8'h08) begin
            errors++;
            $display("FAIL flushk_post: s_ready=%0b out_valid=%0b in0=%h in7=%h required 1 1 01 08",
                     bus.s_ready, bus.out_valid, got[0], got[7]);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL flushk_discard: out_valid=%0b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midframe();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i));
        for (int i = 1; i <= 5; i++) send(8'(8'h60 + i));
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.frame_cnt !== 8'd0 || got[0] !== 8'd0 || got[7] !== 8'd0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: out_valid=%0b frame_cnt=%0d in0=%h in7=%h s_ready=%0b required 0 0 00 00 1",
                     bus.out_valid, bus.frame_cnt, got[0], got[7], bus.s_ready);
        end
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(8'h11 + i));
        checks++;
        if (bus.out_valid !== 1'b1 || got[0] !== 8'h11 || got[3] !== 8'h14 || got[7] !== 8'h18) begin
            errors++;
            $display("FAIL rstmid_frame: out_valid=%0b in0=%h in3=%h in7=%h required 1 11 14 18",
                     bus.out_valid, got[0], got[3], got[7]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_wrap();
        int start;
        do_reset();
        @(negedge clk);
        bus.out_ready = 1'b1;
        start = cyc;
        for (int k = 1; k <= 256; k++) begin
            for (int j = 0; j < 8; j++) send(8'(k + j));
            checks++;
            if (bus.out_valid !== 1'b1 || got[0] !== 8'(k) || bus.frame_cnt !== 8'(k - 1)) begin
                errors++;
                $display("FAIL wrap_frame%0d: out_valid=%0b in0=%h frame_cnt=%0d required 1 %h %0d",
                         k, bus.out_valid, got[0], bus.frame_cnt, 8'(k), 8'(k - 1));
            end
        end
        checks++;
        if (cyc - start !== 2048) begin
            errors++; $display("FAIL wrap_throughput: cycles=%0d required 2048", cyc - start);
        end
        @(negedge clk);
        checks++;
        if (bus.frame_cnt !== 8'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_cnt: frame_cnt=%0d out_valid=%0b required 0 0", bus.frame_cnt, bus.out_valid);
        end
    endtask

    initial begin
        bus.s_valid = 0; bus.s_data = 0; bus.flush = 0; bus.out_ready = 0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_backpressure();
        test_flush_partial();
        test_flush_parked();
        test_reset_midframe();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
